// File: rtl/convolution_cfg_pkg.sv
// conv_pkg: shared sizing, latency and default-kernel definitions for convolution_cfg
package conv_pkg;
    localparam int LATENCY = 5;
    localparam int TAPS = 9;
    localparam int CENTER = 4;
    function automatic int acc_w(input int data_w, input int coef_w);
        return data_w + coef_w + 5;
    endfunction
    function automatic int coef_idx(input int r, input int c);
        return r * 3 + c;
    endfunction
    // sharpen: -1 everywhere, 9 at the centre tap
    function automatic int sharpen(input int idx);
        return idx == CENTER ? 9 : -1;
    endfunction
endpackage

// File: rtl/convolution_cfg_if.sv
// convolution_cfg_if: pixel column stream, shadow coefficient write port and result bus
interface convolution_cfg_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int OUT_W = 8
);
    import conv_pkg::*;
    localparam int ACC_W = acc_w(DATA_W, COEF_W);
    logic i_valid;
    logic i_done;
    logic [3*DATA_W-1:0] i_data;
    logic coef_we;
    logic [3:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic o_valid;
    logic o_img_done;
    logic [OUT_W-1:0] o_data;
    logic signed [ACC_W-1:0] o_data_raw;
    modport master (
        output i_valid, i_done, i_data, coef_we, coef_addr, coef_wdata,
        input o_valid, o_img_done, o_data, o_data_raw
    );
    modport slave (
        input i_valid, i_done, i_data, coef_we, coef_addr, coef_wdata,
        output o_valid, o_img_done, o_data, o_data_raw
    );
endinterface

// File: rtl/convolution_cfg_coef_bank.sv
// conv_coef_bank: shadow/active kernel registers; active reloads from shadow after an image's last column
module conv_coef_bank import conv_pkg::*; #(
    parameter int COEF_W = 16
) (
    input logic clk,
    input logic reset,
    input logic we,
    input logic swap,
    input logic [3:0] addr,
    input logic signed [COEF_W-1:0] wdata,
    output logic [TAPS*COEF_W-1:0] active
);
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] act [TAPS];
    logic swap_q;
    // The copy lands one edge after the done column so its products still use the old kernel;
    // shadow then already holds any write made in the done cycle.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            swap_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= COEF_W'(sharpen(i));
                act[i] <= COEF_W'(sharpen(i));
            end
        end else begin
            swap_q <= swap;
            if (we && addr < 4'(TAPS)) shadow[addr] <= wdata;
            if (swap_q) act <= shadow;
        end
    always_comb
        for (int i = 0; i < TAPS; i++) active[i*COEF_W +: COEF_W] = act[i];
endmodule

// File: rtl/convolution_cfg.sv
// convolution_cfg: runtime-programmable 3x3 convolution, 5-stage pipeline with double-buffered kernel
module convolution_cfg import conv_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0
) (
    input logic clk,
    input logic reset,
    convolution_cfg_if.slave bus
);
    localparam int ACC_W = acc_w(DATA_W, COEF_W);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] MAX = (ACC_W+1)'((1 << OUT_W) - 1);
    logic [DATA_W-1:0] win [3][3];
    logic [1:0] warm;
    logic [LATENCY-1:0] vld, dne;
    logic [TAPS*COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod [TAPS];
    logic signed [ACC_W-1:0] row [3];
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W:0] rounded, shifted;
    conv_coef_bank #(.COEF_W(COEF_W)) u_bank (
        .clk(clk),
        .reset(reset),
        .we(bus.coef_we),
        .swap(bus.i_valid && bus.i_done),
        .addr(bus.coef_addr),
        .wdata(bus.coef_wdata),
        .active(coef)
    );
    always_comb begin
        rounded = (ACC_W+1)'(total) + RND;
        shifted = rounded >>> SHIFT;
    end
    assign bus.o_valid = vld[LATENCY-1];
    assign bus.o_img_done = dne[LATENCY-1];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            win <= '{default: '0};
            warm <= '0;
            vld <= '0;
            dne <= '0;
            prod <= '{default: '0};
            row <= '{default: '0};
            total <= '0;
            bus.o_data <= '0;
            bus.o_data_raw <= '0;
        end else begin
            vld <= {vld[LATENCY-2:0], bus.i_valid && warm == 2'd2};
            dne <= {dne[LATENCY-2:0], bus.i_valid && bus.i_done};
            if (bus.i_valid) begin
                for (int r = 0; r < 3; r++)
                    win[r] <= '{bus.i_data[(2-r)*DATA_W +: DATA_W], win[r][0], win[r][1]};
                warm <= bus.i_done ? 2'd0 : warm + {1'b0, warm != 2'd2};
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    prod[coef_idx(r, c)] <= $signed(coef[coef_idx(r, c)*COEF_W +: COEF_W]) * $signed({1'b0, win[r][c]});
            for (int r = 0; r < 3; r++)
                row[r] <= ACC_W'(prod[r*3]) + ACC_W'(prod[r*3+1]) + ACC_W'(prod[r*3+2]);
            total <= row[0] + row[1] + row[2];
            bus.o_data_raw <= total;
            bus.o_data <= shifted < 0 ? '0 : shifted > MAX ? OUT_W'(MAX) : OUT_W'(shifted);
        end
endmodule

// File: tb/tb_convolution_cfg.sv
// tb_convolution_cfg: drives SHIFT=0 and SHIFT=4 instances with one stream, checked against a behavioural model
module tb_convolution_cfg;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    convolution_cfg_if #(.DATA_W(8), .COEF_W(16), .OUT_W(8)) b0 ();
    convolution_cfg_if #(.DATA_W(8), .COEF_W(16), .OUT_W(8)) b4 ();
    assign b4.i_valid = b0.i_valid;
    assign b4.i_done = b0.i_done;
    assign b4.i_data = b0.i_data;
    assign b4.coef_we = b0.coef_we;
    assign b4.coef_addr = b0.coef_addr;
    assign b4.coef_wdata = b0.coef_wdata;

    convolution_cfg #(.DATA_W(8), .COEF_W(16), .OUT_W(8), .SHIFT(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    convolution_cfg #(.DATA_W(8), .COEF_W(16), .OUT_W(8), .SHIFT(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

    typedef struct { bit v; bit d; bit chk; longint raw; } exp_t;
    exp_t q[$];
    int shd[9], act[9], win[3][3], warm;
    int checks = 0, errors = 0;

    function automatic longint pix(input longint raw, input int sh);
        longint r = raw + (sh > 0 ? (longint'(1) << (sh - 1)) : 0);
        r = r >>> sh;
        return r < 0 ? 0 : (r > 255 ? 255 : r);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            shd[i] = (i == 4) ? 9 : -1;
            act[i] = shd[i];
        end
        win = '{default: 0};
        warm = 0;
        q.delete();
        repeat (4) q.push_back('{v: 0, d: 0, chk: 1, raw: 0});
    endtask

    task automatic pulse_reset();
        b0.i_valid = 0;
        b0.i_done = 0;
        b0.coef_we = 0;
        reset = 0;
        #1;
        check("reset o_valid s0", b0.o_valid, 0);
        check("reset o_img_done s0", b0.o_img_done, 0);
        check("reset o_data s0", b0.o_data, 0);
        check("reset o_data_raw s0", b0.o_data_raw, 0);
        check("reset o_valid s4", b4.o_valid, 0);
        check("reset o_img_done s4", b4.o_img_done, 0);
        check("reset o_data s4", b4.o_data, 0);
        check("reset o_data_raw s4", b4.o_data_raw, 0);
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    // One clock: drive a column and/or coefficient write, advance the model, check what leaves the pipe.
    task automatic step(input bit v, input bit d = 0, input int p0 = 0, input int p1 = 0, input int p2 = 0,
                        input bit we = 0, input int a = 0, input int wd = 0);
        exp_t e;
        longint s = 0;
        b0.i_valid = v;
        b0.i_done = d;
        b0.i_data = {8'(p0), 8'(p1), 8'(p2)};
        b0.coef_we = we;
        b0.coef_addr = 4'(a);
        b0.coef_wdata = 16'(wd);
        @(posedge clk);
        e = '{v: v && warm == 2, d: v && d, chk: v && warm == 2, raw: 0};
        if (v) begin
            for (int r = 0; r < 3; r++) begin
                win[r][2] = win[r][1];
                win[r][1] = win[r][0];
            end
            win[0][0] = p0;
            win[1][0] = p1;
            win[2][0] = p2;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += longint'(act[r*3+c]) * win[r][c];
            e.raw = s;
            warm = d ? 0 : (warm == 2 ? 2 : warm + 1);
        end
        if (we && a < 9) shd[a] = wd;
        if (v && d) act = shd;
        q.push_back(e);
        #1;
        e = q.pop_front();
        check("o_valid s0", b0.o_valid, e.v);
        check("o_valid s4", b4.o_valid, e.v);
        check("o_img_done s0", b0.o_img_done, e.d);
        check("o_img_done s4", b4.o_img_done, e.d);
        if (e.chk) begin
            check("o_data_raw s0", b0.o_data_raw, e.raw);
            check("o_data_raw s4", b4.o_data_raw, e.raw);
            check("o_data s0", b0.o_data, pix(e.raw, 0));
            check("o_data s4", b4.o_data, pix(e.raw, 4));
        end
    endtask

    function automatic int rpx();
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        b0.i_valid = 0;
        b0.i_done = 0;
        b0.i_data = '0;
        b0.coef_we = 0;
        b0.coef_addr = '0;
        b0.coef_wdata = '0;
        #2;
        pulse_reset();
        // flat image under the sharpen kernel
        for (int i = 0; i < 6; i++) step(1, i == 5, 100, 100, 100);
        repeat (5) step(0);
        // bright centre saturates high, dark centre saturates low
        step(1, 0, 100, 100, 100);
        step(1, 0, 100, 200, 100);
        step(1, 0, 100, 100, 100);
        step(1, 0, 255, 255, 255);
        step(1, 0, 255, 0, 255);
        step(1, 1, 255, 255, 255);
        repeat (5) step(0);
        // identity loaded mid-frame; centre tap written in the done cycle; address 12 ignored
        for (int i = 0; i < 8; i++) step(1, 0, rpx(), rpx(), rpx(), 1, i < 4 ? i : i + 1, 0);
        step(1, 0, rpx(), rpx(), rpx(), 1, 12, 77);
        step(1, 1, rpx(), rpx(), rpx(), 1, 4, 1);
        for (int i = 0; i < 6; i++) step(1, i == 5, rpx(), rpx(), rpx());
        repeat (5) step(0);
        // all-ones kernel, flat 16
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1, i, 1);
        step(1, 1, 16, 16, 16);
        for (int i = 0; i < 4; i++) step(1, i == 3, 16, 16, 16);
        repeat (5) step(0);
        // random kernels, pixels and valid gaps
        for (int f = 0; f < 5; f++) begin
            int n;
            n = 0;
            while (n < 12) begin
                bit v;
                v = $urandom_range(0, 2) != 0;
                step(v, v && n == 11, rpx(), rpx(), rpx(), $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, 15)), f < 2 ? int'($urandom_range(0, 20)) - 10 : int'($urandom_range(0, 511)) - 256);
                n += int'(v);
            end
        end
        repeat (5) step(0);
        // reset while columns are in flight, then a fresh frame under the restored sharpen kernel
        for (int i = 0; i < 5; i++) step(1, 0, rpx(), rpx(), rpx());
        pulse_reset();
        for (int i = 0; i < 7; i++) step(1, i == 6, rpx(), rpx(), rpx());
        repeat (6) step(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
